word_line_sequencer: RTL
========================

Name: word_line_sequencer

Overview:
Parametrised word-line sequencer for the memory array: accepts a start address and burst length, then steps through consecutive words. For each word it drives a registered one-hot word-select bus and a one-cycle read or write strobe. It generalises the 3-to-8 select decoder to 2**ADDR_W words and adds burst sequencing, wrap-around, abort and a done handshake. It sits between the memory control logic and the word-line/strobe inputs of the memory array.

Parameters:
ADDR_W, 3, address width; N_WORDS = 2**ADDR_W word lines (derived localparam, not overridable).
LEN_W, 3, burst-length field width; a burst covers burst_len+1 words, from 1 to 2**LEN_W.

Ports:
clk  in  1  single clock, all state updates on its rising edge.
rst_n  in  1  reset, asynchronous and active-low.
sel  in  1  chip select; a request is accepted only when sel=1.
req  in  1  start request; sampled in IDLE only.
write  in  1  1=write burst, 0=read burst; latched at accept.
start_addr  in  ADDR_W  first word address; bit 0 is LSB.
burst_len  in  LEN_W  number of words minus one; latched at accept.
abort  in  1  synchronous burst abort.
busy  out  1  high in every state except IDLE.
S  out  N_WORDS  one-hot word select; S[i] selects address value i.
we  out  1  write strobe.
re  out  1  read strobe.
cur_addr  out  ADDR_W  address currently selected.
done  out  1  one-cycle pulse at normal burst completion.

Behaviour:
- All outputs are driven from flops or from decode of registered state only; no combinational path from inputs to outputs.
- Reset (rst_n=0, any time, including mid-burst): state=IDLE; S=0, we=0, re=0, busy=0, done=0, cur_addr=0, remaining count=0. Leaving reset, the block is in IDLE with no strobe.
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: S=0, strobes=0. On an edge with sel=1 && req=1: latch addr<=start_addr, rem<=burst_len, wr<=write; go to SETUP.
- SETUP: S=onehot(addr), we=re=0 (address setup cycle). Next state is STROBE.
- STROBE: S holds; we=wr, re=~wr; exactly one strobe high, for one cycle. If rem==0, go to DONE. Otherwise addr<=addr+1 mod N_WORDS, rem<=rem-1, go to SETUP.
- DONE: S=0, strobes=0, done=1 for one cycle. Next state is IDLE. busy is 1 in DONE.
- Latency: with the accept edge at T, the first S is valid after edge T+1, the first strobe after T+2, and done after T+2*(burst_len+1)+1. busy falls one cycle after done.
- Wrap-around: the address increments modulo N_WORDS (7 -> 0 for ADDR_W=3). A burst longer than N_WORDS revisits words.
- req, write, start_addr, burst_len and sel are ignored outside IDLE; no queuing.
- abort=1 in SETUP, STROBE or DONE: next state is IDLE, S=0, strobes=0, no done pulse. A strobe already asserted in the current cycle completes; no further strobe is issued. abort in IDLE has no effect.
- abort and req in the same cycle while IDLE: req wins (abort has no effect in IDLE).
- Invariants: S has at most one bit high; S is zero whenever state is IDLE or DONE; we and re are never high together.
- cur_addr mirrors the internal addr register and holds its last value in IDLE.

Decomposition:
- Shared header word_line_defs.vh holds the state encoding localparams (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, DONE=2'd3) and the default ADDR_W/LEN_W values.
- One natural sub-module: addr_onehot_decoder (parameter ADDR_W; inputs addr and en; output one-hot of width 2**ADDR_W). It is purely combinational, with en driven from the registered state, and is reused by the future read-mux selector.

Test Plan:
- Single write: sel=1, req=1, write=1, start_addr=0, burst_len=0 -> S=8'b0000_0001 for 2 cycles; we=1 in the 2nd cycle only; done pulses 1 cycle later; busy high for 3 cycles.
- Mapping sweep: single-word reads at start_addr=0..7 -> S[start_addr] is the only bit high; re pulses once per burst; we stays 0.
- Wrap burst: start_addr=6, burst_len=3, write=0 -> cur_addr sequence 6,7,0,1 with S[6],S[7],S[0],S[1]; 4 re pulses, 2 cycles apart; done 9 cycles after accept.
- Abort: start_addr=2, burst_len=7, abort=1 in the STROBE of the 3rd word (addr 4) -> that strobe completes; next cycle state=IDLE, S=0, busy=0; no done pulse; total we count is 3.
- Ignored inputs: assert req with new start_addr=5 mid-burst, and req with sel=0 in IDLE -> neither changes the sequence or leaves IDLE; busy stays 0 for the sel=0 case.
- Reset mid-burst: pull rst_n low asynchronously between edges during SETUP -> S, we, re, busy, done and cur_addr go to 0 immediately; after release, a new req starts cleanly from its start_addr.

Source files
------------

// File: rtl/word_line_sequencer_pkg.sv
// Shared definitions for the word-line sequencer: default geometry and the
// sequencer state encoding.
package word_line_sequencer_pkg;

    localparam int ADDR_W_DEFAULT = 3;
    localparam int LEN_W_DEFAULT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } wls_state_e;

    // True in the states where a word line is being driven.
    function automatic logic is_addr_phase(input wls_state_e st);
        return (st == ST_SETUP) || (st == ST_STROBE);
    endfunction

endpackage

// File: rtl/word_line_sequencer_decoder.sv
// Purely combinational address-to-one-hot decoder with an enable; the
// enable must come from registered state so the result can feed a flop.
module addr_onehot_decoder
    import word_line_sequencer_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEFAULT,
    localparam int N_OUT  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              en_i,
    output logic [N_OUT-1:0]  onehot_o
);

    // One bit per address value; all zero while disabled.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end else begin
            onehot_o = '0;
        end
    end

endmodule

// File: rtl/word_line_sequencer.sv
// Burst word-line sequencer: per word, an address setup cycle followed by a
// single read or write strobe cycle, with wrap-around, abort and a done pulse.
// All outputs are flops loaded from the current registered state, so they
// trail the state register by one cycle.
module word_line_sequencer
    import word_line_sequencer_pkg::*;
#(
    parameter  int ADDR_W  = ADDR_W_DEFAULT,
    parameter  int LEN_W   = LEN_W_DEFAULT,
    localparam int N_WORDS = 2**ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel,
    input  logic               req,
    input  logic               write,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [LEN_W-1:0]   burst_len,
    input  logic               abort,
    output logic               busy,
    output logic [N_WORDS-1:0] S,
    output logic               we,
    output logic               re,
    output logic [ADDR_W-1:0]  cur_addr,
    output logic               done
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    wls_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                wr_q, wr_d;

    logic [N_WORDS-1:0]  s_q, s_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic                sel_en_s;

    // Next-state logic: accept in IDLE, alternate SETUP/STROBE per word, abort to IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel && req) begin
                    addr_d  = start_addr;
                    rem_d   = burst_len;
                    wr_d    = write;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    rem_d   = rem_q - LEN_ONE;
                    state_d = ST_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values from registered state; abort suppresses anything not yet visible.
    always_comb begin
        sel_en_s   = 1'b0;
        we_d       = 1'b0;
        re_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cur_addr_d = addr_q;
        if (!abort) begin
            sel_en_s = is_addr_phase(state_q);
            we_d     = (state_q == ST_STROBE) && wr_q;
            re_d     = (state_q == ST_STROBE) && !wr_q;
            busy_d   = (state_q != ST_IDLE);
            done_d   = (state_q == ST_DONE);
        end else begin
            sel_en_s = 1'b0;
        end
    end

    addr_onehot_decoder #(
        .ADDR_W (ADDR_W)
    ) u_decoder (
        .addr_i   (addr_q),
        .en_i     (sel_en_s),
        .onehot_o (s_d)
    );

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            wr_q       <= 1'b0;
            s_q        <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cur_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wr_q       <= wr_d;
            s_q        <= s_d;
            we_q       <= we_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cur_addr_q <= cur_addr_d;
        end
    end

    assign S        = s_q;
    assign we       = we_q;
    assign re       = re_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cur_addr = cur_addr_q;

endmodule
